icache_sa2: RTL

//  2-way set-associative instruction cache with multi-word lines and an LRU replacement policy.
//  It sits between the fetch unit and the memory controller.

---
 rtl/icache_sa2.sv | 127 ++++++++++++
 1 files changed

// File: rtl/icache_sa2.sv
// 2-way set-associative instruction cache with multi-word lines and 1-bit LRU per set.
// Combinational lookup; on a miss the whole line is refilled one word per mem_ack.
module icache_sa2 #(
  parameter int unsigned SET_BITS  = 6,
  parameter int unsigned WORD_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        hit,
  output logic [31:0] inst,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned TAG_BITS = 32 - 2 - WORD_BITS - SET_BITS;
  localparam int unsigned SETS     = 1 << SET_BITS;
  localparam int unsigned WORDS    = 1 << WORD_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state;

  logic [1:0][SETS-1:0]  valid;
  logic [SETS-1:0]       lru;
  logic [TAG_BITS-1:0]   tag_mem  [2][SETS];
  logic [31:0]           data_mem [2][SETS*WORDS];

  logic [TAG_BITS-1:0]   r_tag;
  logic [SET_BITS-1:0]   r_set;
  logic                  victim;
  logic [WORD_BITS-1:0]  cnt;
  logic [WORD_BITS-1:0]  cnt_next;

  logic [TAG_BITS-1:0]   f_tag;
  logic [SET_BITS-1:0]   f_set;
  logic [WORD_BITS-1:0]  f_word;
  logic [1:0]            way_hit;
  logic                  hit_way;
  logic                  fill_we;
  logic                  fill_last;
  logic                  unused_addr_bits;

  assign f_tag            = fetch_addr[31 -: TAG_BITS];
  assign f_set            = fetch_addr[SET_BITS+WORD_BITS+1 -: SET_BITS];
  assign f_word           = fetch_addr[WORD_BITS+1:2];
  assign unused_addr_bits = ^fetch_addr[1:0];
  assign cnt_next         = cnt + 1'b1;
  assign busy             = (state == REFILL);

  // Both ways can never match the same tag, so way1's match alone selects the way.
  always_comb begin
    way_hit[0] = valid[0][f_set] && (tag_mem[0][f_set] == f_tag);
    way_hit[1] = valid[1][f_set] && (tag_mem[1][f_set] == f_tag);
    hit_way    = way_hit[1];
    hit        = (state == IDLE) && fetch_valid && (|way_hit);
    inst       = hit ? data_mem[hit_way][{f_set, f_word}] : '0;
  end

  always_comb begin
    fill_we   = !rst && rdy && !flush && (state == REFILL) && mem_ack;
    fill_last = fill_we && (cnt == '1);
  end

  // Storage arrays carry no reset so they can map onto RAM; valid bits gate visibility.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[victim][{r_set, cnt}] <= mem_data;
    end
    if (fill_last) begin
      tag_mem[victim][r_set] <= r_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      lru      <= '0;
      state    <= IDLE;
      cnt      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      r_tag    <= '0;
      r_set    <= '0;
      victim   <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        valid   <= '0;
        lru     <= '0;
        state   <= IDLE;
        mem_req <= 1'b0;
        cnt     <= '0;
      end else if (state == REFILL) begin
        if (mem_ack) begin
          cnt      <= cnt_next;
          mem_addr <= {r_tag, r_set, cnt_next, 2'b00};
          if (cnt == '1) begin
            valid[victim][r_set] <= 1'b1;
            lru[r_set]           <= ~victim;
            mem_req              <= 1'b0;
            state                <= IDLE;
          end
        end
      end else if (fetch_valid) begin
        if (hit) begin
          lru[f_set] <= ~hit_way;
        end else begin
          r_tag    <= f_tag;
          r_set    <= f_set;
          victim   <= !valid[0][f_set] ? 1'b0 :
                      !valid[1][f_set] ? 1'b1 : lru[f_set];
          cnt      <= '0;
          mem_req  <= 1'b1;
          mem_addr <= {f_tag, f_set, {(WORD_BITS+2){1'b0}}};
          state    <= REFILL;
        end
      end
    end
  end

endmodule
